// File: rtl/event_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : event_apb_pkg
//  Description : Items shared by the event-to-APB master and the APB event
//                accumulator: event addresses, event index encoding, APB
//                completer FSM state type and the address decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package event_apb_pkg;

  localparam logic [31:0] EV_ADDR_A = 32'hABBA_0000;
  localparam logic [31:0] EV_ADDR_B = 32'hBAFF_0000;
  localparam logic [31:0] EV_ADDR_C = 32'hCAFE_0000;

  typedef enum logic [1:0] {
    EV_A    = 2'd0,
    EV_B    = 2'd1,
    EV_C    = 2'd2,
    EV_NONE = 2'd3
  } ev_idx_e;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Full 32-bit compare; anything else is unmapped.
  function automatic ev_idx_e decode_event_addr(input logic [31:0] addr);
    case (addr)
      EV_ADDR_A: return EV_A;
      EV_ADDR_B: return EV_B;
      EV_ADDR_C: return EV_C;
      default:   return EV_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_acc_cell.sv
`default_nettype none
// ============================================================================
//  Module      : event_acc_cell
//  Description : One saturating event accumulator with sticky overflow.
//                A clear in the same cycle as an add is applied first, so the
//                result is just the added value.
//  Ports       : clk, reset      - clock, async active-high reset
//                i_add_en        - add i_add_val this cycle
//                i_add_val       - increment
//                i_clr           - zero accumulator and overflow flag
//                o_acc           - current accumulator value
//                o_ovf           - sticky saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module event_acc_cell #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_add_en,
  input  logic [ACC_W-1:0] i_add_val,
  input  logic             i_clr,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;

  // Clear-before-add: the add starts from zero when a clear coincides.
  assign w_base = i_clr ? '0 : r_acc;
  assign w_sum  = {1'b0, w_base} + {1'b0, i_add_val};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_add_en) begin
      r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
      r_ovf <= (r_ovf & ~i_clr) | w_sum[ACC_W];
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/apb_event_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : apb_event_accumulator
//  Description : APB completer terminating event writes into three saturating
//                accumulators, with fixed wait states, error response on
//                unmapped addresses, APB read-back and a sideband read/clear.
//  Ports       : clk, reset                - clock, async active-high reset
//                apb_*_i / apb_*_o         - APB completer interface
//                rd_sel_i, rd_clr_i        - sideband select / clear
//                rd_data_o                 - selected accumulator (0 for sel 3)
//                ovf_o                     - sticky saturation flags {C,B,A}
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_event_accumulator
  import event_apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ACC_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apb_psel_i,
  input  logic             apb_penable_i,
  input  logic [31:0]      apb_paddr_i,
  input  logic             apb_pwrite_i,
  input  logic [31:0]      apb_pwdata_i,
  output logic             apb_pready_o,
  output logic [31:0]      apb_prdata_o,
  output logic             apb_pslverr_o,
  input  logic [1:0]       rd_sel_i,
  input  logic             rd_clr_i,
  output logic [ACC_W-1:0] rd_data_o,
  output logic [2:0]       ovf_o
);

  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

  apb_state_e       r_state;
  apb_state_e       w_state_nxt;
  logic [3:0]       r_wait_cnt;
  logic [3:0]       w_wait_nxt;
  logic             w_setup;

  ev_idx_e          r_idx;
  logic             r_write;
  logic [ACC_W-1:0] r_wdata;

  logic             w_pready;
  logic             w_commit;

  // Entry 3 is a constant zero so EV_NONE / rd_sel_i=3 read back as zero.
  logic [ACC_W-1:0] w_acc [4];
  logic [2:0]       w_ovf;

  // Only the low ACC_W bits of write data carry the increment.
  logic             w_unused_pwdata;
  assign w_unused_pwdata = ^apb_pwdata_i;

  // --------------------------------------------------------------------------
  // State register and transfer capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_idx      <= EV_NONE;
      r_write    <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_setup) begin
        r_idx   <= decode_event_addr(apb_paddr_i);
        r_write <= apb_pwrite_i;
        r_wdata <= apb_pwdata_i[ACC_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_setup     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A stray penable without a setup phase is ignored.
        if (apb_psel_i && !apb_penable_i) begin
          w_state_nxt = ST_ACCESS;
          w_wait_nxt  = c_WAIT_INIT;
          w_setup     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!apb_psel_i) begin
          // Aborted transfer: nothing is committed.
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = 4'd0;
        end else if (r_wait_cnt != 4'd0) begin
          w_wait_nxt = r_wait_cnt - 4'd1;
        end else if (apb_penable_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: response is driven only in the pready cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_pready      = 1'b0;
    w_commit      = 1'b0;
    apb_prdata_o  = '0;
    apb_pslverr_o = 1'b0;
    if (r_state == ST_ACCESS && apb_psel_i && apb_penable_i && r_wait_cnt == 4'd0) begin
      w_pready = 1'b1;
      if (r_idx == EV_NONE) begin
        apb_pslverr_o = 1'b1;
      end else if (r_write) begin
        w_commit = 1'b1;
      end else begin
        apb_prdata_o = 32'(w_acc[r_idx]);
      end
    end
  end

  assign apb_pready_o = w_pready;

  // --------------------------------------------------------------------------
  // Accumulator cells
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 3; k++) begin : g_cell
    logic w_add_en;
    logic w_clr;

    assign w_add_en = w_commit && (r_idx == ev_idx_e'(k));
    assign w_clr    = rd_clr_i && (rd_sel_i == 2'(k));

    event_acc_cell #(
      .ACC_W (ACC_W)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .i_add_en  (w_add_en),
      .i_add_val (r_wdata),
      .i_clr     (w_clr),
      .o_acc     (w_acc[k]),
      .o_ovf     (w_ovf[k])
    );
  end

  assign w_acc[3]  = '0;
  assign rd_data_o = w_acc[rd_sel_i];
  assign ovf_o     = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_apb_event_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_event_accumulator
//  Description : Self-checking bench for apb_event_accumulator. Two instances:
//                zero-wait / 4-bit and two-wait / 16-bit. Expected APB
//                responses go into per-instance queues and are checked by a
//                monitor when pready is seen; sideband values are compared
//                against a reference model of the event totals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_event_accumulator;

  localparam int NW [2] = '{0, 2};
  localparam int AW [2] = '{4, 16};

  typedef struct {
    logic [31:0] prdata;
    logic        pslverr;
    int          waits;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] paddr   [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];
  logic [1:0]  rd_sel  [2];
  logic        rd_clr  [2];
  logic [2:0]  ovf     [2];
  logic [3:0]  rd_data0;
  logic [15:0] rd_data1;

  exp_t   q0[$];
  exp_t   q1[$];
  int     acnt [2];
  longint acc_m [2][3];
  int     ovf_m [2][3];
  int     checks;
  int     errors;

  apb_event_accumulator #(.WAIT_CYCLES(0), .ACC_W(4)) dut0 (
    .clk(clk), .reset(reset),
    .apb_psel_i(psel[0]), .apb_penable_i(penable[0]), .apb_paddr_i(paddr[0]),
    .apb_pwrite_i(pwrite[0]), .apb_pwdata_i(pwdata[0]), .apb_pready_o(pready[0]),
    .apb_prdata_o(prdata[0]), .apb_pslverr_o(pslverr[0]),
    .rd_sel_i(rd_sel[0]), .rd_clr_i(rd_clr[0]), .rd_data_o(rd_data0), .ovf_o(ovf[0])
  );

  apb_event_accumulator #(.WAIT_CYCLES(2), .ACC_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .apb_psel_i(psel[1]), .apb_penable_i(penable[1]), .apb_paddr_i(paddr[1]),
    .apb_pwrite_i(pwrite[1]), .apb_pwdata_i(pwdata[1]), .apb_pready_o(pready[1]),
    .apb_prdata_o(prdata[1]), .apb_pslverr_o(pslverr[1]),
    .rd_sel_i(rd_sel[1]), .rd_clr_i(rd_clr[1]), .rd_data_o(rd_data1), .ovf_o(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int addr_idx(input logic [31:0] a);
    case (a)
      32'hABBA_0000: return 0;
      32'hBAFF_0000: return 1;
      32'hCAFE_0000: return 2;
      default:       return 3;
    endcase
  endfunction

  function automatic longint acc_max(input int d);
    return (longint'(1) << AW[d]) - 1;
  endfunction

  function automatic longint side_data(input int d);
    return (d == 0) ? longint'(rd_data0) : longint'(rd_data1);
  endfunction

  function automatic longint ovf_exp(input int d);
    return longint'(ovf_m[d][0] + 2 * ovf_m[d][1] + 4 * ovf_m[d][2]);
  endfunction

  task automatic model_clear(input int d, input int sel);
    if (sel < 3) begin
      acc_m[d][sel] = 0;
      ovf_m[d][sel] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin
        acc_m[d][k] = 0;
        ovf_m[d][k] = 0;
      end
  endtask

  // Sideband read of every select plus the overflow flags.
  task automatic check_side(input int d);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      rd_sel[d] = 2'(s);
      #1;
      chk($sformatf("rd_data d%0d sel%0d", d, s), side_data(d), (s < 3) ? acc_m[d][s] : 0);
    end
    chk($sformatf("ovf d%0d", d), longint'(ovf[d]), ovf_exp(d));
  endtask

  task automatic side_clr(input int d, input int sel);
    @(negedge clk);
    rd_sel[d] = 2'(sel);
    rd_clr[d] = 1'b1;
    @(posedge clk);
    #1;
    rd_clr[d] = 1'b0;
    model_clear(d, sel);
    check_side(d);
  endtask

  // One APB transfer; optional sideband clear in the commit cycle and
  // optional scrambling of paddr/pwdata during the access phase.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic clr, input int csel,
                      input logic scramble);
    exp_t   e;
    int     idx;
    int     n;
    longint sum;
    idx       = addr_idx(addr);
    e.pslverr = (idx == 3);
    e.prdata  = '0;
    e.waits   = 1 + NW[d];
    if (idx != 3 && !wr) e.prdata = 32'(acc_m[d][idx]);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    if (clr) model_clear(d, csel);
    if (idx != 3 && wr) begin
      sum = acc_m[d][idx] + (longint'(data) & acc_max(d));
      if (sum > acc_max(d)) begin
        acc_m[d][idx] = acc_max(d);
        ovf_m[d][idx] = 1;
      end else begin
        acc_m[d][idx] = sum;
      end
    end

    @(posedge clk);
    #1;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    paddr[d]   = addr;
    pwrite[d]  = wr;
    pwdata[d]  = data;
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    if (scramble) begin
      paddr[d]  = $urandom;
      pwdata[d] = $urandom;
    end
    n = 0;
    @(negedge clk);
    while (!pready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!pready[d]) begin
      chk($sformatf("pready timeout d%0d", d), 0, 1);
      if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end else if (clr) begin
      rd_sel[d] = 2'(csel);
      rd_clr[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    rd_clr[d]  = 1'b0;
    check_side(d);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    int r;
    r = $urandom_range(0, 9);
    base = (r < 3) ? 32'hABBA_0000 : (r < 6) ? 32'hBAFF_0000 : 32'hCAFE_0000;
    if (r == 8) base = $urandom;
    if (r == 9) base = base ^ (32'd1 << $urandom_range(0, 31));
    return base;
  endfunction

  // Monitor: compares every pready cycle against the queued expectation and
  // checks response quiescence in all other cycles.
  always @(negedge clk) begin : mon
    exp_t e;
    logic empty;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (psel[d] && !penable[d]) acnt[d] = 0;
        else if (psel[d]) acnt[d]++;
        if (pready[d]) begin
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            chk($sformatf("unexpected pready d%0d", d), 1, 0);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("prdata d%0d", d), longint'(prdata[d]), longint'(e.prdata));
            chk($sformatf("pslverr d%0d", d), longint'(pslverr[d]), longint'(e.pslverr));
            chk($sformatf("latency d%0d", d), longint'(acnt[d]), longint'(e.waits));
          end
        end else begin
          chk($sformatf("quiet prdata d%0d", d), longint'(prdata[d]), 0);
          chk($sformatf("quiet pslverr d%0d", d), longint'(pslverr[d]), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s pready d%0d", tag, d), longint'(pready[d]), 0);
      chk($sformatf("%s prdata d%0d", tag, d), longint'(prdata[d]), 0);
      chk($sformatf("%s pslverr d%0d", tag, d), longint'(pslverr[d]), 0);
      chk($sformatf("%s ovf d%0d", tag, d), longint'(ovf[d]), 0);
      for (int s = 0; s < 4; s++) begin
        rd_sel[d] = 2'(s);
        #1;
        chk($sformatf("%s rd_data d%0d sel%0d", tag, d, s), side_data(d), 0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = '0; pwrite[d] = 1'b0;
      pwdata[d] = '0; rd_sel[d] = 2'd3; rd_clr[d] = 1'b0; acnt[d] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Zero-wait, 4-bit instance.
    xfer(0, 32'hABBA_0000, 1'b1, 32'd3, 1'b0, 3, 1'b0);
    xfer(0, 32'hCAFE_0000, 1'b1, 32'd9, 1'b0, 3, 1'b0);
    xfer(0, 32'hCAFE_0000, 1'b1, 32'd9, 1'b0, 3, 1'b0);
    side_clr(0, 2);
    xfer(0, 32'hABBA_0000, 1'b1, 32'hFFFF_FF07, 1'b0, 3, 1'b1);
    xfer(0, 32'hABBA_0000, 1'b1, 32'd7, 1'b1, 0, 1'b0);
    xfer(0, 32'hABBA_0000, 1'b0, 32'd0, 1'b0, 3, 1'b0);
    side_clr(0, 3);

    // Two-wait, 16-bit instance.
    xfer(1, 32'hBAFF_0000, 1'b1, 32'd5, 1'b0, 3, 1'b0);
    xfer(1, 32'hBAFF_0000, 1'b0, 32'd0, 1'b0, 3, 1'b1);
    xfer(1, 32'h0000_1234, 1'b1, 32'd77, 1'b0, 3, 1'b0);
    xfer(1, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 3, 1'b0);
    xfer(1, 32'hABBA_0000, 1'b1, 32'd100, 1'b1, 2, 1'b0);

    // Abort during wait states: nothing committed.
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'hBAFF_0000;
    pwrite[1] = 1'b1; pwdata[1] = 32'd9;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    check_side(1);

    // Reset during the access phase of the next transfer.
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'hABBA_0000;
    pwrite[1] = 1'b1; pwdata[1] = 32'd4;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_side(0);
    check_side(1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 2; d++) begin
        xfer(d, rand_addr(), 1'($urandom_range(0, 3) != 0), $urandom,
             1'($urandom_range(0, 4) == 0), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
        if ($urandom_range(0, 9) == 0) side_clr(d, $urandom_range(0, 3));
      end
    end

    repeat (2) @(negedge clk);
    chk("queue0 drained", longint'(q0.size()), 0);
    chk("queue1 drained", longint'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
